calc_port_driver: RTL and testbench
===================================

Name: calc_port_driver

Overview:
- RTL request driver for one calc2 DUT port; sits directly upstream of the DUT wrapper.
- Takes whole operations (cmd, operand1, operand2) over a valid/ready handshake and serialises each into the calc2 two-cycle request protocol.
- Allocates one of 4 calc2 tags per in-flight operation and matches DUT responses back to their tags.
- Returns completed results and flags timeouts, stray responses and illegal operations.

Parameters:
- NUM_TAGS, 4, number of tags in flight; fixed by the 2-bit calc2 tag field.
- TIMEOUT, 100, cycles after issue without a response before the tag is retired with an error.
- DATA_W, 32, operand and result width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- op_valid  in  1  upstream operation valid.
- op_ready  out  1  driver can accept an operation this cycle.
- op_cmd  in  4  calc2 command: 1 add, 2 sub, 5 shl, 6 shr.
- op_a  in  DATA_W  operand1.
- op_b  in  DATA_W  operand2.
- req_cmd  out  4  to DUT req_cmd_in.
- req_data  out  DATA_W  to DUT req_data_in.
- req_tag  out  2  to DUT req_tag_in.
- out_resp  in  2  from DUT: 0 none, 1 ok, 2 overflow/invalid, 3 internal error.
- out_data  in  DATA_W  from DUT result.
- out_tag  in  2  from DUT response tag.
- res_valid  out  1  one-cycle result strobe.
- res_resp  out  2  response code; 3 also means timeout.
- res_data  out  DATA_W  result data; 0 on timeout.
- res_tag  out  2  tag of the completed operation.
- res_cmd  out  4  command that was issued on that tag.
- outstanding  out  3  count of busy tags, 0..4.
- stray_err  out  1  pulse: response received on a non-busy tag.
- illegal_op  out  1  pulse: op_cmd == 0 consumed and dropped.

Behaviour:
- Reset (reset_n low at an edge): all outputs 0; FSM goes to IDLE; tag busy bitmap, timeout counters and stored cmds are cleared.
- Reset mid-operation abandons in-flight tags with no results emitted. Any DUT responses arriving afterwards are reported via stray_err.
- FSM has two states, IDLE and SEND_B.
- op_ready = (state == IDLE) && (a free tag exists in the registered busy bitmap). It is combinational from registered state only and never depends on op_valid.
- Accept occurs when op_valid && op_ready at an edge.
- Accept with op_cmd != 0:
  - Next cycle drives req_cmd = op_cmd, req_data = op_a, req_tag = lowest free tag.
  - Marks that tag busy, stores op_b and op_cmd, loads the tag's timeout counter, and goes to SEND_B.
- SEND_B lasts one cycle: drives req_cmd = 0, req_data = stored op_b, req_tag = 0, then returns to IDLE.
- In every other cycle req_cmd, req_data and req_tag are all 0.
- Maximum issue rate is one operation per 2 cycles.
- Accept with op_cmd == 0: nothing is driven to the DUT and no tag is used; illegal_op pulses for 1 cycle on the next cycle.
- Commands 3, 4 and 7-15 are forwarded unchanged; the DUT reports them as invalid.
- Response handling, when out_resp != 0 and tag out_tag is busy:
  - Next cycle: res_valid = 1, res_resp = out_resp, res_data = out_data, res_tag = out_tag, res_cmd = stored cmd.
  - The tag is freed at the same edge.
- Response on a non-busy tag: stray_err pulses the next cycle; no result is emitted and state is unchanged.
- There is no backpressure on results; the consumer must accept every res_valid.
- Timeout:
  - Each busy tag's counter decrements every cycle.
  - At 0 the tag retires with res_resp = 3, res_data = 0.
  - A valid response and a timeout on the same tag in the same cycle: the response wins and no timeout result is produced.
  - A response on one tag and a timeout on another in the same cycle: the response is emitted first; the expired tag stays busy with its counter held at 0 and retires on the next free result cycle.
  - Multiple simultaneous expiries retire lowest tag first, one per cycle.
- A tag freed at edge N is allocatable from cycle N+1 at the earliest, because op_ready is computed from the registered bitmap.
- outstanding always equals the popcount of the busy bitmap, registered.

Test Plan:
- Reset then op add(cmd 1, a=5, b=7): req = (1, 5, tag 0) then (0, 7, 0); DUT resp (1, 12, tag 0) -> res_valid with resp 1, data 12, tag 0, cmd 1; outstanding goes 0 -> 1 -> 0.
- Five back-to-back ops with no responses: tags 0, 1, 2, 3 issued at cycles 1, 3, 5, 7; op_ready low afterward; outstanding = 4. Respond on tag 2 -> next accepted op gets tag 2.
- Out-of-order responses on tags 3, 0, 1 in consecutive cycles -> three res_valid pulses in the same order, each carrying the correct stored cmd.
- TIMEOUT=10, no response -> res_resp 3, data 0, tag 0 exactly 10 cycles after issue. A response at the expiry cycle yields only the response result.
- Response on idle tag 1 -> stray_err pulse, no res_valid. op_cmd 0 accepted -> illegal_op pulse, req bus stays 0.
- reset_n low during SEND_B with 2 tags busy -> all outputs 0 next cycle, outstanding 0; subsequent responses on those tags -> stray_err.

Source files
------------

// File: rtl/calc_port_driver_if.sv
// calc_port_driver_if: operation input, calc2 request/response and result signals of one driver port.
interface calc_port_driver_if #(parameter int DATA_W = 32);
    logic              op_valid;
    logic              op_ready;
    logic [3:0]        op_cmd;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [3:0]        req_cmd;
    logic [DATA_W-1:0] req_data;
    logic [1:0]        req_tag;
    logic [1:0]        out_resp;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_tag;
    logic              res_valid;
    logic [1:0]        res_resp;
    logic [DATA_W-1:0] res_data;
    logic [1:0]        res_tag;
    logic [3:0]        res_cmd;
    logic [2:0]        outstanding;
    logic              stray_err;
    logic              illegal_op;
    modport slave (
        input  op_valid, op_cmd, op_a, op_b, out_resp, out_data, out_tag,
        output op_ready, req_cmd, req_data, req_tag, res_valid, res_resp, res_data, res_tag, res_cmd,
               outstanding, stray_err, illegal_op
    );
    modport master (
        output op_valid, op_cmd, op_a, op_b, out_resp, out_data, out_tag,
        input  op_ready, req_cmd, req_data, req_tag, res_valid, res_resp, res_data, res_tag, res_cmd,
               outstanding, stray_err, illegal_op
    );
endinterface

// File: rtl/calc_port_driver.sv
// calc_port_driver: serialises operations into calc2 two-cycle requests, tracks 4 tags and returns results/timeouts.
module calc_port_driver #(
    parameter int NUM_TAGS = 4,
    parameter int TIMEOUT  = 100,
    parameter int DATA_W   = 32
) (
    input logic               clk,
    input logic               reset_n,
    calc_port_driver_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic {IDLE, SEND_B} state_e;
    state_e              state_q, state_d;
    logic [NUM_TAGS-1:0] busy_q, busy_d;
    logic [CW-1:0]       cnt_q [NUM_TAGS];
    logic [CW-1:0]       cnt_d [NUM_TAGS];
    logic [3:0]          cmd_q [NUM_TAGS];
    logic [3:0]          cmd_d [NUM_TAGS];
    logic [DATA_W-1:0]   b_q, b_d;
    logic [3:0]          req_cmd_q, req_cmd_d;
    logic [DATA_W-1:0]   req_data_q, req_data_d;
    logic [1:0]          req_tag_q, req_tag_d;
    logic                res_valid_q, res_valid_d;
    logic [1:0]          res_resp_q, res_resp_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic [1:0]          res_tag_q, res_tag_d;
    logic [3:0]          res_cmd_q, res_cmd_d;
    logic [2:0]          outstanding_q, outstanding_d;
    logic                stray_q, stray_d;
    logic                illegal_q, illegal_d;
    logic                free_any, exp_any, accept, resp_hit;
    logic [1:0]          free_tag, exp_tag;
    // Descending scan so the lowest free / expired tag is the one that sticks.
    always_comb begin
        free_any = 1'b0;
        free_tag = '0;
        exp_any  = 1'b0;
        exp_tag  = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_any = 1'b1;
                free_tag = 2'(i);
            end
            if (busy_q[i] && cnt_q[i] == '0) begin
                exp_any = 1'b1;
                exp_tag = 2'(i);
            end
        end
    end
    assign bus.op_ready = (state_q == IDLE) && free_any;
    assign accept       = bus.op_valid && bus.op_ready;
    assign resp_hit     = (bus.out_resp != 2'd0) && busy_q[bus.out_tag];
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        b_d         = b_q;
        req_cmd_d   = '0;
        req_data_d  = (state_q == SEND_B) ? b_q : '0;
        req_tag_d   = '0;
        res_valid_d = 1'b0;
        res_resp_d  = '0;
        res_data_d  = '0;
        res_tag_d   = '0;
        res_cmd_d   = '0;
        stray_d     = (bus.out_resp != 2'd0) && !busy_q[bus.out_tag];
        illegal_d   = accept && bus.op_cmd == 4'd0;
        if (state_q == SEND_B) state_d = IDLE;
        for (int i = 0; i < NUM_TAGS; i++)
            if (busy_q[i] && cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CW'(1);
        if (accept && bus.op_cmd != 4'd0) begin
            state_d          = SEND_B;
            busy_d[free_tag] = 1'b1;
            cnt_d[free_tag]  = CW'(TIMEOUT - 1);
            cmd_d[free_tag]  = bus.op_cmd;
            b_d              = bus.op_b;
            req_cmd_d        = bus.op_cmd;
            req_data_d       = bus.op_a;
            req_tag_d        = free_tag;
        end
        // A real response always takes the single result slot; expired tags wait at 0.
        if (resp_hit) begin
            busy_d[bus.out_tag] = 1'b0;
            res_valid_d         = 1'b1;
            res_resp_d          = bus.out_resp;
            res_data_d          = bus.out_data;
            res_tag_d           = bus.out_tag;
            res_cmd_d           = cmd_q[bus.out_tag];
        end else if (exp_any) begin
            busy_d[exp_tag] = 1'b0;
            res_valid_d     = 1'b1;
            res_resp_d      = 2'd3;
            res_tag_d       = exp_tag;
            res_cmd_d       = cmd_q[exp_tag];
        end
        outstanding_d = 3'($countones(busy_d));
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            busy_q        <= '0;
            b_q           <= '0;
            req_cmd_q     <= '0;
            req_data_q    <= '0;
            req_tag_q     <= '0;
            res_valid_q   <= 1'b0;
            res_resp_q    <= '0;
            res_data_q    <= '0;
            res_tag_q     <= '0;
            res_cmd_q     <= '0;
            outstanding_q <= '0;
            stray_q       <= 1'b0;
            illegal_q     <= 1'b0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                cnt_q[i] <= '0;
                cmd_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            cnt_q         <= cnt_d;
            cmd_q         <= cmd_d;
            b_q           <= b_d;
            req_cmd_q     <= req_cmd_d;
            req_data_q    <= req_data_d;
            req_tag_q     <= req_tag_d;
            res_valid_q   <= res_valid_d;
            res_resp_q    <= res_resp_d;
            res_data_q    <= res_data_d;
            res_tag_q     <= res_tag_d;
            res_cmd_q     <= res_cmd_d;
            outstanding_q <= outstanding_d;
            stray_q       <= stray_d;
            illegal_q     <= illegal_d;
        end
    end
    assign bus.req_cmd     = req_cmd_q;
    assign bus.req_data    = req_data_q;
    assign bus.req_tag     = req_tag_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_resp    = res_resp_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_tag     = res_tag_q;
    assign bus.res_cmd     = res_cmd_q;
    assign bus.outstanding = outstanding_q;
    assign bus.stray_err   = stray_q;
    assign bus.illegal_op  = illegal_q;
endmodule

// File: tb/tb_calc_port_driver.sv
// tb_calc_port_driver: directed bench with a result scoreboard for calc_port_driver (TIMEOUT = 10).
module tb_calc_port_driver;
    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
        logic [3:0]  cmd;
    } res_t;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    res_t sb [$];
    calc_port_driver_if #(.DATA_W(32)) bus ();
    calc_port_driver #(.NUM_TAGS(4), .TIMEOUT(10), .DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", name, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic set_op(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = v;
        bus.op_cmd   = c;
        bus.op_a     = a;
        bus.op_b     = b;
    endtask
    task automatic set_resp(input logic [1:0] r, input logic [31:0] d, input logic [1:0] t);
        bus.out_resp = r;
        bus.out_data = d;
        bus.out_tag  = t;
    endtask
    // Every result strobe is matched against the oldest expected result.
    always @(negedge clk) begin
        if (bus.res_valid === 1'b1) begin
            if (sb.size() == 0) check("res_unexpected", 64'd1, 64'd0);
            else begin
                res_t e;
                e = sb.pop_front();
                check("res_content", 64'({bus.res_resp, bus.res_data, bus.res_tag, bus.res_cmd}), 64'(e));
            end
        end
    end
    initial begin
        logic [3:0] cmds [4];
        cmds = '{4'd1, 4'd2, 4'd5, 4'd6};
        set_op(1'b0, 4'd0, 32'd0, 32'd0);
        set_resp(2'd0, 32'd0, 2'd0);
        tick();
        tick();
        check("rst_req_cmd", 64'(bus.req_cmd), 64'd0);
        check("rst_req_data", 64'(bus.req_data), 64'd0);
        check("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("rst_outstanding", 64'(bus.outstanding), 64'd0);
        check("rst_flags", 64'({bus.stray_err, bus.illegal_op}), 64'd0);
        reset_n = 1'b1;
        tick();
        // Single add, answered right after the operand-B cycle
        set_op(1'b1, 4'd1, 32'd5, 32'd7);
        check("add_ready", 64'(bus.op_ready), 64'd1);
        tick();
        set_op(1'b0, 4'd0, 32'd0, 32'd0);
        check("add_req_a", 64'({bus.req_cmd, bus.req_data, bus.req_tag}), 64'({4'd1, 32'd5, 2'd0}));
        check("add_outst1", 64'(bus.outstanding), 64'd1);
        check("add_ready_sendb", 64'(bus.op_ready), 64'd0);
        tick();
        check("add_req_b", 64'({bus.req_cmd, bus.req_data, bus.req_tag}), 64'({4'd0, 32'd7, 2'd0}));
        set_resp(2'd1, 32'd12, 2'd0);
        sb.push_back('{2'd1, 32'd12, 2'd0, 4'd1});
        tick();
        set_resp(2'd0, 32'd0, 2'd0);
        check("add_res_valid", 64'(bus.res_valid), 64'd1);
        check("add_outst0", 64'(bus.outstanding), 64'd0);
        check("add_idle_bus", 64'({bus.req_cmd, bus.req_data}), 64'd0);
        tick();
        check("add_res_pulse", 64'(bus.res_valid), 64'd0);
        // Fill all four tags back to back
        for (int i = 0; i < 4; i++) begin
            set_op(1'b1, cmds[i], 32'(i + 16), 32'(i + 32));
            tick();
            set_op(1'b0, 4'd0, 32'd0, 32'd0);
            check("fill_tag", 64'({bus.req_cmd, bus.req_tag}), 64'({cmds[i], 2'(i)}));
            tick();
        end
        check("full_outst", 64'(bus.outstanding), 64'd4);
        check("full_ready", 64'(bus.op_ready), 64'd0);
        set_op(1'b1, 4'd1, 32'd9, 32'd9);
        set_resp(2'd1, 32'h22, 2'd2);
        sb.push_back('{2'd1, 32'h22, 2'd2, 4'd5});
        tick();
        set_resp(2'd0, 32'd0, 2'd0);
        check("full_no_issue", 64'(bus.req_cmd), 64'd0);
        check("free2_res", 64'(bus.res_valid), 64'd1);
        check("free2_ready", 64'(bus.op_ready), 64'd1);
        tick();
        set_op(1'b0, 4'd0, 32'd0, 32'd0);
        check("realloc_tag2", 64'({bus.req_cmd, bus.req_tag}), 64'({4'd1, 2'd2}));
        check("realloc_outst", 64'(bus.outstanding), 64'd4);
        // Out-of-order answers; tags 0 and 1 are at their expiry cycle when answered
        set_resp(2'd2, 32'h33, 2'd3);
        sb.push_back('{2'd2, 32'h33, 2'd3, 4'd6});
        tick();
        check("ooo_t3", 64'({bus.res_valid, bus.res_tag}), 64'({1'b1, 2'd3}));
        set_resp(2'd1, 32'h10, 2'd0);
        sb.push_back('{2'd1, 32'h10, 2'd0, 4'd1});
        tick();
        check("ooo_t0", 64'({bus.res_valid, bus.res_tag}), 64'({1'b1, 2'd0}));
        set_resp(2'd3, 32'h11, 2'd1);
        sb.push_back('{2'd3, 32'h11, 2'd1, 4'd2});
        tick();
        set_resp(2'd0, 32'd0, 2'd0);
        check("ooo_t1", 64'({bus.res_valid, bus.res_tag}), 64'({1'b1, 2'd1}));
        check("ooo_outst", 64'(bus.outstanding), 64'd1);
        // Remaining tag 2 retires by timeout
        sb.push_back('{2'd3, 32'd0, 2'd2, 4'd1});
        tick();
        check("ooo_no_extra", 64'(bus.res_valid), 64'd0);
        for (int k = 0; k < 20 && bus.res_valid !== 1'b1; k++) tick();
        check("to2_seen", 64'(bus.res_valid), 64'd1);
        tick();
        check("to2_outst", 64'(bus.outstanding), 64'd0);
        // Timeout exactly 10 cycles after issue
        set_op(1'b1, 4'd6, 32'd8, 32'd1);
        sb.push_back('{2'd3, 32'd0, 2'd0, 4'd6});
        tick();
        set_op(1'b0, 4'd0, 32'd0, 32'd0);
        check("to_issue_tag", 64'({bus.req_cmd, bus.req_tag}), 64'({4'd6, 2'd0}));
        for (int k = 1; k < 10; k++) begin
            tick();
            check("to_early", 64'(bus.res_valid), 64'd0);
        end
        tick();
        check("to_exact", 64'(bus.res_valid), 64'd1);
        tick();
        // Response on the expiry cycle suppresses the timeout
        set_op(1'b1, 4'd2, 32'd20, 32'd3);
        tick();
        set_op(1'b0, 4'd0, 32'd0, 32'd0);
        for (int k = 1; k < 10; k++) tick();
        set_resp(2'd1, 32'd17, 2'd0);
        sb.push_back('{2'd1, 32'd17, 2'd0, 4'd2});
        tick();
        set_resp(2'd0, 32'd0, 2'd0);
        check("race_res", 64'(bus.res_valid), 64'd1);
        tick();
        check("race_no_timeout", 64'(bus.res_valid), 64'd0);
        // Stray response and illegal command
        set_resp(2'd1, 32'h55, 2'd1);
        tick();
        set_resp(2'd0, 32'd0, 2'd0);
        check("stray_pulse", 64'({bus.stray_err, bus.res_valid}), 64'({1'b1, 1'b0}));
        tick();
        check("stray_clear", 64'(bus.stray_err), 64'd0);
        set_op(1'b1, 4'd0, 32'hAA, 32'hBB);
        tick();
        set_op(1'b0, 4'd0, 32'd0, 32'd0);
        check("illegal_pulse", 64'(bus.illegal_op), 64'd1);
        check("illegal_bus_a", 64'({bus.req_cmd, bus.req_data, bus.outstanding}), 64'd0);
        tick();
        check("illegal_clear", 64'(bus.illegal_op), 64'd0);
        check("illegal_bus_b", 64'(bus.req_data), 64'd0);
        // Reset during SEND_B with two tags busy
        set_op(1'b1, 4'd1, 32'd1, 32'hB0);
        tick();
        set_op(1'b0, 4'd0, 32'd0, 32'd0);
        tick();
        set_op(1'b1, 4'd2, 32'd2, 32'hB1);
        tick();
        set_op(1'b0, 4'd0, 32'd0, 32'd0);
        check("pre_rst_outst", 64'(bus.outstanding), 64'd2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_rst_bus", 64'({bus.req_cmd, bus.req_data, bus.req_tag}), 64'd0);
        check("mid_rst_outst", 64'(bus.outstanding), 64'd0);
        check("mid_rst_res", 64'(bus.res_valid), 64'd0);
        tick();
        set_resp(2'd1, 32'd3, 2'd1);
        tick();
        check("post_rst_stray1", 64'({bus.stray_err, bus.res_valid}), 64'({1'b1, 1'b0}));
        set_resp(2'd1, 32'd1, 2'd0);
        tick();
        set_resp(2'd0, 32'd0, 2'd0);
        check("post_rst_stray0", 64'({bus.stray_err, bus.res_valid}), 64'({1'b1, 1'b0}));
        for (int k = 0; k < 15; k++) tick();
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
